// File: rtl/btn_pkg.sv
// Shared defaults and width helpers for the push-button front end.
package btn_pkg;

    localparam int N_BTN_DEF      = 4;
    localparam int DEB_CYCLES_DEF = 4;
    localparam int CNT_W_DEF      = 4;
    localparam int LED_W_DEF      = 4;

    function automatic int sel_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Debounce counter must hold values up to DEB_CYCLES-1.
    function automatic int deb_cnt_width(input int d);
        return (d < 1) ? 1 : $clog2(d + 1);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button channel: two-flop synchroniser, stable-level debouncer and a
// registered one-cycle press strobe; accept is the same-edge press condition.
module btn_debounce
    import btn_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic level,
    output logic press,
    output logic accept
);

    localparam int DCW = deb_cnt_width(DEB_CYCLES);
    localparam logic [DCW-1:0] LAST = DCW'(DEB_CYCLES - 1);

    logic           s1_reg;
    logic           s2_reg;
    logic           stable_reg;
    logic           stable_next;
    logic           press_reg;
    logic [DCW-1:0] cnt_reg;
    logic [DCW-1:0] cnt_next;

    always_comb begin
        stable_next = stable_reg;
        cnt_next    = '0;
        accept      = 1'b0;
        if (s2_reg != stable_reg) begin
            if (cnt_reg == LAST) begin
                stable_next = s2_reg;
                accept      = s2_reg;
            end else begin
                cnt_next = cnt_reg + DCW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_reg     <= 1'b0;
            s2_reg     <= 1'b0;
            stable_reg <= 1'b0;
            cnt_reg    <= '0;
            press_reg  <= 1'b0;
        end else begin
            s1_reg     <= btn;
            s2_reg     <= s1_reg;
            stable_reg <= stable_next;
            cnt_reg    <= cnt_next;
            press_reg  <= accept;
        end
    end

    assign level = stable_reg;
    assign press = press_reg;

endmodule

// File: rtl/btn_press_counter.sv
// Multi-channel debounced press counter with LED view of a selected channel.
// Optional build macro BTN_SAT_EN: counters saturate instead of wrapping.
module btn_press_counter
    import btn_pkg::*;
#(
    parameter int N_BTN      = N_BTN_DEF,
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int CNT_W      = CNT_W_DEF,
    parameter int LED_W      = LED_W_DEF,
    parameter int SEL_W      = sel_width(N_BTN)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] BTN,
    input  logic [N_BTN-1:0] clr,
    input  logic [SEL_W-1:0] sel,
    output logic [N_BTN-1:0] debounced,
    output logic [N_BTN-1:0] press_pulse,
    output logic [LED_W-1:0] LEDS
);

    logic [CNT_W-1:0] count [N_BTN];
    logic [N_BTN-1:0] accept;

    generate
        for (genvar gi = 0; gi < N_BTN; gi++) begin : g_chan
            logic [CNT_W-1:0] count_reg;

            btn_debounce #(
                .DEB_CYCLES(DEB_CYCLES)
            ) u_deb (
                .clk   (clk),
                .reset (reset),
                .btn   (BTN[gi]),
                .level (debounced[gi]),
                .press (press_pulse[gi]),
                .accept(accept[gi])
            );

            // Clear wins over a press landing on the same edge.
            always_ff @(posedge clk) begin
                if (reset) begin
                    count_reg <= '0;
                end else if (clr[gi]) begin
                    count_reg <= '0;
                end else if (accept[gi]) begin
`ifdef BTN_SAT_EN
                    if (count_reg != {CNT_W{1'b1}}) begin
                        count_reg <= count_reg + CNT_W'(1);
                    end
`else
                    count_reg <= count_reg + CNT_W'(1);
`endif
                end
            end

            assign count[gi] = count_reg;
        end
    endgenerate

    // Out-of-range selects fall through to zero.
    always_comb begin
        LEDS = '0;
        for (int i = 0; i < N_BTN; i++) begin
            if (sel == SEL_W'(i)) begin
                LEDS = count[i][LED_W-1:0];
            end
        end
    end

endmodule
